// File: rtl/fir_param_core.sv
// Streaming signed FIR filter with serially reloadable, double-buffered coefficients
// and a saturated, registered output.
module fir_param_core #(
  parameter int DATA_W        = 6,
  parameter int COEF_W        = 2,
  parameter int TAPS          = 8,
  parameter int OUT_W         = 8,
  parameter int CLEAR_ON_IDLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     coef_start,
  input  logic                     coef_valid,
  input  logic signed [COEF_W-1:0] coef_in,
  output logic                     coef_done,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  output logic                     busy
);

  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
  localparam int IDX_W  = $clog2(TAPS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]               state;
  logic signed [DATA_W-1:0] x      [TAPS];
  logic signed [COEF_W-1:0] active [TAPS];
  logic signed [COEF_W-1:0] shadow [TAPS];
  logic [IDX_W-1:0]         idx;
  logic                     pend;

  logic                     accept;
  logic                     commit;
  logic                     run_to_idle;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [EXT_W-1:0]  sum_ext;
  logic signed [OUT_W-1:0]  sat_data;
  logic                     sat_flag;

  assign in_ready    = (state != ST_LOAD);
  assign busy        = (state != ST_IDLE);
  // coef_start wins over a simultaneous sample, so that sample is refused.
  assign accept      = in_valid && in_ready && !coef_start;
  assign commit      = (state == ST_LOAD) && coef_valid && (idx == IDX_W'(TAPS - 1));
  assign run_to_idle = (state == ST_RUN) && !in_valid && !coef_start;

  always_comb begin
    prod = '0;
    sum  = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      prod = PROD_W'(x[k]) * PROD_W'(active[k]);
      sum  = sum + ACC_W'(prod);
    end
  end

  assign sum_ext = EXT_W'(sum);

  always_comb begin
    sat_data = sum_ext[OUT_W-1:0];
    sat_flag = 1'b0;
    if (sum_ext > SAT_MAX) begin
      sat_data = SAT_MAX[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (sum_ext < SAT_MIN) begin
      sat_data = SAT_MIN[OUT_W-1:0];
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      pend      <= 1'b0;
      coef_done <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      for (int unsigned k = 0; k < TAPS; k++) begin
        x[k]      <= '0;
        shadow[k] <= '0;
        active[k] <= (k % 2 == 0) ? COEF_W'(1) : '0;
      end
    end else begin
      coef_done <= commit;
      pend      <= accept;
      out_valid <= pend;
      // The sum seen here already reflects the sample accepted on the previous edge.
      if (pend) begin
        out_data <= sat_data;
        out_sat  <= sat_flag;
      end

      case (state)
        ST_IDLE: begin
          if (coef_start)  state <= ST_LOAD;
          else if (accept) state <= ST_RUN;
        end
        ST_RUN: begin
          if (coef_start)     state <= ST_LOAD;
          else if (!in_valid) state <= ST_IDLE;
        end
        ST_LOAD: begin
          if (commit) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        x[0] <= in_data;
        for (int unsigned k = 1; k < TAPS; k++) x[k] <= x[k-1];
      end else if (commit || (run_to_idle && CLEAR_ON_IDLE != 0)) begin
        for (int unsigned k = 0; k < TAPS; k++) x[k] <= '0;
      end

      if (state == ST_LOAD && coef_valid) begin
        shadow[idx] <= coef_in;
        idx         <= commit ? '0 : idx + IDX_W'(1);
      end

      // The last coefficient bypasses the shadow bank straight into the active set.
      if (commit) begin
        for (int unsigned k = 0; k < TAPS - 1; k++) active[k] <= shadow[k];
        active[TAPS-1] <= coef_in;
      end
    end
  end

endmodule

// File: tb/tb_fir_param_core.sv
// Randomised and directed bench for fir_param_core, both CLEAR_ON_IDLE settings side by side,
// checked every cycle against a transaction-level reference model.
module tb_fir_param_core;

  localparam int TAPS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic signed [5:0]   in_data = '0;
  logic                coef_start = 1'b0;
  logic                coef_valid = 1'b0;
  logic signed [1:0]   coef_in = '0;

  logic                o_ready [2];
  logic                o_done  [2];
  logic                o_valid [2];
  logic                o_sat   [2];
  logic                o_busy  [2];
  logic signed [7:0]   o_data  [2];

  fir_param_core #(.DATA_W(6), .COEF_W(2), .TAPS(TAPS), .OUT_W(8), .CLEAR_ON_IDLE(0)) dut_keep (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_ready[0]), .in_data(in_data),
    .coef_start(coef_start), .coef_valid(coef_valid), .coef_in(coef_in), .coef_done(o_done[0]),
    .out_valid(o_valid[0]), .out_data(o_data[0]), .out_sat(o_sat[0]), .busy(o_busy[0])
  );

  fir_param_core #(.DATA_W(6), .COEF_W(2), .TAPS(TAPS), .OUT_W(8), .CLEAR_ON_IDLE(1)) dut_clear (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_ready[1]), .in_data(in_data),
    .coef_start(coef_start), .coef_valid(coef_valid), .coef_in(coef_in), .coef_done(o_done[1]),
    .out_valid(o_valid[1]), .out_data(o_data[1]), .out_sat(o_sat[1]), .busy(o_busy[1])
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: sample history per instance, coefficient list, pending shadow list.
  int hist [2][TAPS];
  int coefs [TAPS];
  int shadow [$];
  bit loading, running, pend;
  int last_val [2];
  bit last_sat [2];
  bit e_done, e_valid;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int fsum(input int c);
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += coefs[k] * hist[c][k];
    return s;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
      last_val[c] = 0;
      last_sat[c] = 1'b0;
    end
    for (int k = 0; k < TAPS; k++) coefs[k] = (k % 2 == 0) ? 1 : 0;
    shadow.delete();
    loading = 1'b0; running = 1'b0; pend = 1'b0;
    e_done = 1'b0; e_valid = 1'b0;
  endtask

  task automatic model_advance(input bit v, input int d, input bit s, input bit cv, input int ci);
    bit acc, commit, to_idle;
    e_valid = pend;
    if (pend) begin
      for (int c = 0; c < 2; c++) begin
        int sm = fsum(c);
        last_sat[c] = (sm > 127) || (sm < -128);
        last_val[c] = (sm > 127) ? 127 : (sm < -128) ? -128 : sm;
      end
    end
    acc     = v && !loading && !s;
    to_idle = running && !loading && !v && !s;
    commit  = 1'b0;
    if (loading && cv) begin
      shadow.push_back(ci);
      commit = (shadow.size() == TAPS);
    end
    for (int c = 0; c < 2; c++) begin
      if (acc) begin
        for (int k = TAPS - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = d;
      end else if (commit || (to_idle && c == 1)) begin
        for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
      end
    end
    if (commit) begin
      for (int k = 0; k < TAPS; k++) coefs[k] = shadow[k];
      shadow.delete();
    end
    if (loading) begin
      if (commit) loading = 1'b0;
    end else if (s) begin
      loading = 1'b1;
      running = 1'b0;
    end else begin
      running = v;
    end
    pend   = acc;
    e_done = commit;
  endtask

  task automatic step(input bit r, input bit v, input int d, input bit s, input bit cv, input int ci);
    int dd, cc;
    reset = r; in_valid = v; in_data = 6'(d);
    coef_start = s; coef_valid = cv; coef_in = 2'(ci);
    dd = int'(in_data);
    cc = int'(coef_in);
    @(posedge clk);
    #1;
    if (r) model_reset();
    else   model_advance(v, dd, s, cv, cc);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("in_ready[clr=%0d]", c),  32'(o_ready[c]), 32'(!loading));
      chk($sformatf("busy[clr=%0d]", c),      32'(o_busy[c]),  32'(loading || running));
      chk($sformatf("coef_done[clr=%0d]", c), 32'(o_done[c]),  32'(e_done));
      chk($sformatf("out_valid[clr=%0d]", c), 32'(o_valid[c]), 32'(e_valid));
      chk($sformatf("out_data[clr=%0d]", c),  32'(o_data[c]),  last_val[c]);
      chk($sformatf("out_sat[clr=%0d]", c),   32'(o_sat[c]),   32'(last_sat[c]));
    end
  endtask

  task automatic feed(input int d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic load_all(input int cf [TAPS]);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
    for (int k = 0; k < TAPS; k++) step(1'b0, 1'b0, 0, 1'b0, 1'b1, cf[k]);
    idle(1);
  endtask

  initial begin
    int cf [TAPS];

    // Reset values
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);

    // Default-coefficient impulse
    feed(5);
    for (int i = 0; i < 7; i++) feed(0);
    idle(3);

    // Positive then negative saturation
    for (int k = 0; k < TAPS; k++) cf[k] = 1;
    load_all(cf);
    for (int i = 0; i < 8; i++) feed(31);
    idle(3);
    for (int k = 0; k < TAPS; k++) cf[k] = -1;
    load_all(cf);
    for (int i = 0; i < 8; i++) feed(31);
    idle(3);

    // Load mid-run, with samples offered during LOAD
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) feed($urandom_range(0, 63) - 32);
    step(1'b0, 1'b1, 7, 1'b1, 1'b0, 0);
    for (int k = 0; k < TAPS; k++) cf[k] = (k == 0) ? 1 : (k == 1) ? -1 : 0;
    for (int k = 0; k < TAPS; k++) step(1'b0, 1'b1, 9, 1'b0, 1'b1, cf[k]);
    feed(3);
    for (int i = 0; i < 7; i++) feed(0);
    idle(2);

    // Reset mid-load, then default impulse again
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 0, 1'b0, 1'b1, -1);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    feed(5);
    for (int i = 0; i < 7; i++) feed(0);
    idle(3);

    // Idle gap with history kept or cleared
    feed(10);
    idle(1);
    feed(0);
    feed(0);
    idle(3);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 63) - 32,
           $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) - 2);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_param_core.md
Name: fir_param_core

Overview:
Parametrised, streaming signed FIR filter with run-time reloadable coefficients. It is the generalised successor to the fixed 8-tap, 6-bit core: tap count, data, coefficient and output widths are all configurable. It adds valid/ready handshakes, a serial coefficient-load channel with double-buffered commit, and output saturation. It sits between the sample source and the output pins of the top-level wrapper.

Parameters:
DATA_W, 6, signed input sample width
COEF_W, 2, signed coefficient width
TAPS, 8, number of taps (>=2)
OUT_W, 8, signed output width; full-precision sum saturates to this width
CLEAR_ON_IDLE, 1, 1 = delay line zeroed on RUN->IDLE; 0 = history retained

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  sample strobe
in_ready  out  1  core accepts samples; low only in LOAD
in_data  in  DATA_W  signed sample
coef_start  in  1  request coefficient reload
coef_valid  in  1  coefficient strobe (LOAD only)
coef_in  in  COEF_W  signed coefficient
coef_done  out  1  one-cycle pulse after commit
out_valid  out  1  out_data valid this cycle
out_data  out  OUT_W  saturated filter output
out_sat  out  1  out_data was clipped (qualified by out_valid)
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. Delay line and shadow bank zeroed. Active coefficients: tap k = 1 for even k, 0 for odd k. Outputs in_ready=1, coef_done=0, out_valid=0, out_data=0, out_sat=0.
- Reset mid-load discards the partial shadow bank and restores the default coefficients.
- States:
  - IDLE -> RUN: on accepted sample.
  - IDLE or RUN -> LOAD: on coef_start. coef_start has priority over in_valid in the same cycle; that sample is not accepted.
  - RUN -> IDLE: on any cycle with in_valid=0 and coef_start=0.
  - LOAD -> IDLE: only on commit. coef_start is ignored while in LOAD.
- Accept: in_valid && in_ready. The accepting edge shifts the delay line (x[0]=in_data, x[k]=x[k-1]). Nothing shifts without an accept.
- Datapath:
  - sum = Σ c[k]*x[k], computed in ACC_W = DATA_W+COEF_W+clog2(TAPS) bits, signed.
  - The edge after an accept registers out_data and asserts out_valid for one cycle.
  - Latency: sample accepted at edge N gives out_valid high during the cycle after edge N+1. Fully pipelined, one result per accepted sample, back-to-back.
- Saturation:
  - sum > 2^(OUT_W-1)-1 -> out_data = max, out_sat=1.
  - sum < -2^(OUT_W-1) -> out_data = min, out_sat=1.
  - Otherwise out_data = sum, out_sat=0.
  - out_data and out_sat hold their last values while out_valid=0.
- LOAD:
  - A result already in flight when LOAD is entered still emits normally.
  - Each coef_valid cycle writes coef_in into shadow[idx] and increments idx, which starts at 0. The first coefficient received is tap 0 (newest sample).
  - On the TAPS-th coefficient edge, the commit happens:
    - active <= shadow;
    - delay line zeroed;
    - idx reset to 0;
    - state -> IDLE.
  - coef_done pulses high in the following cycle.
  - coef_valid outside LOAD is ignored.
- CLEAR_ON_IDLE=1: the RUN->IDLE edge zeroes the delay line. Applies only to that transition; out_valid is unaffected.

Test Plan:
1. Defaults impulse (defaults params): reset, then feed 5,0,0,0,0,0,0,0 back-to-back -> out_data 5,0,5,0,5,0,5,0, each 2 edges after its sample; out_sat=0 throughout.
2. Positive saturation: load eight coefficients of 1 (coef_done one cycle after the 8th strobe), then feed 31 x8 continuously -> out_data 31,62,93,124,127,127,127,127; out_sat=1 from the 5th result.
3. Negative saturation: load eight coefficients of -1, then feed 31 x8 -> out_data -31,-62,-93,-124,-128,-128,-128,-128; out_sat=1 from the 5th result.
4. Load mid-run: coef_start during continuous input -> in_ready=0 the next cycle; the in-flight result still emits; samples are not accepted during LOAD. After the 8th coef_valid: busy=0, in_ready=1; the next impulse of 3 with coefficients [2's-comp 1,-1,0,...] gives 3,-3,0,...; no stale history appears.
5. Reset mid-load: 4 coef_valid strobes, then reset -> state IDLE, coef_done never pulses; the impulse response equals scenario 1.
6. Idle gap, both CLEAR_ON_IDLE settings: feed 10, then a 1-cycle in_valid gap, then 0 with default coefficients.
   - CLEAR_ON_IDLE=1: second result 0.
   - CLEAR_ON_IDLE=0: second result 0 (tap1=0), and a further 0 gives 10.
